// File: rtl/tdm_mux_2to1.sv
// tdm_mux_2to1: merges two valid/ready streams onto one shared data line plus
// a select bit. Each channel has a one-word holding buffer, and a round-robin
// arbiter feeds a single output register that drives the 1:2 demux.
module tdm_mux_2to1 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in1_valid,
   output logic             in1_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sel,
   output logic             out_valid,
   input  logic             out_ready
);

   // Channel holding buffers (stage p0)
   logic [WIDTH-1:0] buf0_p0;
   logic [WIDTH-1:0] buf1_p0;
   logic             full0_p0;
   logic             full1_p0;

   // Round-robin pointer: channel granted most recently
   logic             last_gnt;

   logic             take0;
   logic             take1;
   logic             can_load;
   logic             gnt_vld;
   logic             gnt_sel;
   logic             load;

   // A tie goes to the channel that did not win last time; otherwise the
   // only full buffer wins.
   function automatic logic arb_sel(input logic f0, input logic f1, input logic last);
      if (f0 && f1) begin
         return ~last;
      end
      return f1;
   endfunction

   // Ready looks only at registered state, so there is no combinational path
   // from out_ready back to either input.
   assign in0_ready = ~full0_p0 & ~rst;
   assign in1_ready = ~full1_p0 & ~rst;

   assign take0    = in0_valid & in0_ready;
   assign take1    = in1_valid & in1_ready;
   assign can_load = ~out_valid | out_ready;

   // Grant decision for the output register
   always_comb begin
      gnt_vld = full0_p0 | full1_p0;
      gnt_sel = arb_sel(full0_p0, full1_p0, last_gnt);
      load    = can_load & gnt_vld;
   end

   // Buffer payloads carry no reset; the full flags qualify them
   always_ff @(posedge clk) begin
      if (take0) begin
         buf0_p0 <= in0_data;
      end
      if (take1) begin
         buf1_p0 <= in1_data;
      end
   end

   // Buffer occupancy: set on input transfer, cleared when granted. The two
   // cannot coincide because ready requires the buffer to be empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         full0_p0 <= 1'b0;
         full1_p0 <= 1'b0;
      end else begin
         if (take0) begin
            full0_p0 <= 1'b1;
         end else if (load && !gnt_sel) begin
            full0_p0 <= 1'b0;
         end
         if (take1) begin
            full1_p0 <= 1'b1;
         end else if (load && gnt_sel) begin
            full1_p0 <= 1'b0;
         end
      end
   end

   // Output register (stage p1): load a granted word, drain when idle, or
   // hold everything while downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_sel   <= 1'b0;
         out_valid <= 1'b0;
         last_gnt  <= 1'b1;
      end else if (load) begin
         out_data  <= gnt_sel ? buf1_p0 : buf0_p0;
         out_sel   <= gnt_sel;
         out_valid <= 1'b1;
         last_gnt  <= gnt_sel;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
